alu_iter: RTL and testbench

//  Multi-cycle ALU. Consumes the 4-bit ALU control code produced by the ALU control decoder.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_comb.sv | 29 ++
 rtl/alu_iter.sv | 124 ++++++++++++
 tb/tb_alu_iter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: widths, op codes, FSM states.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CTRL_W  = 4;

  // Op codes shared with the ALU control decoder
  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SRA = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: AND/OR/ADD/SUB/SLT on the operands captured at accept.
// SRA and unknown codes yield zero here; shifting is handled by alu_iter.
module alu_comb
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_c_o
);

  logic slt_c;

  assign slt_c = ($signed(a_i) < $signed(b_i));

  // Operation select; add/sub wrap modulo 2^DATA_W
  always_comb begin
    result_c_o = '0;
    unique case (ctrl_i)
      ALU_AND: result_c_o = a_i & b_i;
      ALU_OR:  result_c_o = a_i | b_i;
      ALU_ADD: result_c_o = a_i + b_i;
      ALU_SUB: result_c_o = a_i - b_i;
      ALU_SLT: result_c_o = {{(DATA_W-1){1'b0}}, slt_c};
      default: result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with start/done handshake. SRA iterates one bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, in which case SRA completes in one cycle
// and the SHIFT state, shift counter and busy indication are not built.
module alu_iter
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   comb_res_c;
  logic [SHAMT_W-1:0]  shamt_c;
  logic                accept_c;
`ifndef ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                busy_q, busy_d;
`endif

  assign shamt_c  = src1_i[SHAMT_W-1:0];
  assign accept_c = start_i & ready_q;

  alu_comb u_alu_comb (
    .ctrl_i     (ALUCtrl_i),
    .a_i        (src1_i),
    .b_i        (src2_i),
    .result_c_o (comb_res_c)
  );

  // State, result and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q    <= '0;
      busy_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
`endif
    end
  end

  // Next-state, result update and registered status decode
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          state_d = ST_DONE;
          if (ALUCtrl_i == ALU_SRA) begin
`ifdef ALU_FAST_SHIFT_EN
            result_d = DATA_W'($signed(src2_i) >>> shamt_c);
`else
            result_d = src2_i;
            if (shamt_c != '0) begin
              cnt_d   = shamt_c;
              state_d = ST_SHIFT;
            end
`endif
          end else begin
            result_d = comb_res_c;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      ST_SHIFT: begin
        result_d = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    zero_d  = (result_d == '0);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d != ST_SHIFT);
`ifndef ALU_FAST_SHIFT_EN
    busy_d  = (state_d == ST_SHIFT);
`endif
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
`ifdef ALU_FAST_SHIFT_EN
  assign busy_o   = 1'b0;
`else
  assign busy_o   = busy_q;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vectors with literal expectations
// plus a cycle-level reference model compared on every negative clock edge.
module tb_alu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_iter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .ready_o   (ready),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .zero_o    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op-code table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: r = $signed(b) >>> a[4:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a);
`ifdef ALU_FAST_SHIFT_EN
    return 0;
`else
    return (op == 4'b1111) ? int'(a[4:0]) : 0;
`endif
  endfunction

  // Model: expected outputs for the cycle after each rising edge
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_final = 32'd0;
  logic        m_done  = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_ready = 1'b1;
  int          m_wait  = 0;
  bit          m_on    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_res = 32'd0; m_done = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_wait = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_res = m_final;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_final = ref_alu(ctrl, src1, src2);
        m_wait  = ref_lat(ctrl, src1);
        if (m_wait == 0) begin
          m_res = m_final; m_done = 1'b1;
        end else begin
          m_busy = 1'b1; m_ready = 1'b0;
        end
      end
    end
  end

  // Compare every cycle; result/zero only when no shift is in flight
  always @(negedge clk) begin
    if (m_on) begin
      chk("model_done",  32'(done),  32'(m_done));
      chk("model_busy",  32'(busy),  32'(m_busy));
      chk("model_ready", 32'(ready), 32'(m_ready));
      if (!m_busy) begin
        chk("model_result", result,    m_res);
        chk("model_zero",   32'(zero), 32'(m_res == 32'd0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; ctrl = op; src1 = a; src2 = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; ctrl = 4'd0; src1 = 32'd0; src2 = 32'd0;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  32'(ready), 32'd1);
    chk("rst_busy",   32'(busy),  32'd0);
    chk("rst_done",   32'(done),  32'd0);
    chk("rst_result", result,     32'd0);
    chk("rst_zero",   32'(zero),  32'd1);

    // ADD wraps into the sign bit
    cyc(); issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("add_done",   32'(done), 32'd1);
    chk("add_result", result,    32'h8000_0000);
    chk("add_zero",   32'(zero), 32'd0);

    // SUB to zero, then back-to-back AND issued in the DONE cycle
    cyc(); issue(4'b0110, 32'd5, 32'd5);
    cyc(); issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(negedge clk);
    chk("sub_done",   32'(done), 32'd1);
    chk("sub_result", result,    32'd0);
    chk("sub_zero",   32'(zero), 32'd1);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("and_done",   32'(done), 32'd1);
    chk("and_result", result,    32'hF000_F000);

    // SLT signed both ways, back-to-back
    cyc(); issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    cyc(); issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("slt_neg_lt", result, 32'd1);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("slt_pos_lt", result, 32'd0);

    // OR then unknown code forces result to zero
    cyc(); issue(4'b0001, 32'h0F0F_0000, 32'h0000_00F0);
    cyc(); issue(4'b0011, 32'd5, 32'd6);
    @(negedge clk);
    chk("or_result", result, 32'h0F0F_00F0);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("unk_done",   32'(done), 32'd1);
    chk("unk_result", result,    32'd0);

    // SRA by 4 with start held high while busy
    cyc(); issue(4'b1111, 32'd4, 32'h8000_0000);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      ctrl = 4'b0010;
      @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
      chk("sra4_busy", 32'(busy), 32'd1);
      chk("sra4_nodone", 32'(done), 32'd0);
`endif
    end
    cyc(); start = 1'b0;
    @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    chk("sra4_done",   32'(done), 32'd1);
    chk("sra4_result", result,    32'hF800_0000);
`endif

    // SRA by zero; upper shift-amount bits are ignored
    cyc(); issue(4'b1111, 32'hFFFF_FFE0, 32'h0000_1234);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("sra0_done",   32'(done), 32'd1);
    chk("sra0_result", result,    32'h0000_1234);

    // Extra SRA patterns, checked by the model
    cyc(); issue(4'b1111, 32'd8, 32'hFFFF_0000);
    cyc(); start = 1'b0;
    repeat (10) cyc();
    issue(4'b1111, 32'd3, 32'h7F00_0000);
    cyc(); start = 1'b0;
    repeat (6) cyc();

    // SRA by 31 on a positive value: done at c32
    issue(4'b1111, 32'd31, 32'h4000_0000);
    cyc(); start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      cyc();
      k++;
    end
    @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    chk("sra31_latency", 32'(k), 32'd32);
`endif
    chk("sra31_result", result, 32'd0);

    // Reset during an 8-bit shift aborts it
    cyc(); issue(4'b1111, 32'd8, 32'h8000_0000);
    cyc(); start = 1'b0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("abort_done",   32'(done),  32'd0);
    chk("abort_ready",  32'(ready), 32'd1);
    chk("abort_busy",   32'(busy),  32'd0);
    chk("abort_result", result,     32'd0);
    chk("abort_zero",   32'(zero),  32'd1);
    repeat (10) cyc();

    // Normal operation resumes after the abort
    issue(4'b0010, 32'd3, 32'd4);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("post_add", result, 32'd7);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
